// File: rtl/pre_comp_bank_pipe.sv
// pre_comp_bank_pipe: two-stage pipelined bank of odd multiples I*(2k+1) with valid/ready flow control
module pre_comp_bank_pipe #(
    parameter int LOG2_WIDTH = 4,
    parameter int WIDTH = 2**LOG2_WIDTH,
    parameter int ALPHA_BITS = 2,
    localparam int NUM_ODD = 2**ALPHA_BITS,
    localparam int OUT_W = WIDTH + ALPHA_BITS + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         I,
    input  logic                     in_signed,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_ODD*OUT_W-1:0] bank_out,
    output logic                     out_signed
);
    logic                     s1_valid_q, s2_valid_q, s1_signed_q, out_signed_q;
    logic [OUT_W-1:0]         e_q, e2_q, ext;
    logic [NUM_ODD*OUT_W-1:0] bank_out_q, bank_d;
    logic                     s1_en, s2_en, fire_in;
    assign s2_en      = !s2_valid_q || out_ready;
    assign s1_en      = !s1_valid_q || s2_en;
    assign in_ready   = s1_en && !rst;
    assign fire_in    = in_valid && in_ready;
    assign ext        = {{(ALPHA_BITS+1){in_signed & I[WIDTH-1]}}, I};
    assign out_valid  = s2_valid_q;
    assign bank_out   = bank_out_q;
    assign out_signed = out_signed_q;
    // adder chain: each odd multiple is the previous one plus 2E
    always_comb begin
        logic [OUT_W-1:0] acc;
        bank_d = '0;
        acc = e_q;
        for (int k = 0; k < NUM_ODD; k++) begin
            bank_d[k*OUT_W +: OUT_W] = acc;
            acc = acc + e2_q;
        end
    end
    // pipeline registers; a stage with low enable or a bubble upstream keeps its contents
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            s1_signed_q  <= 1'b0;
            out_signed_q <= 1'b0;
            e_q          <= '0;
            e2_q         <= '0;
            bank_out_q   <= '0;
        end else begin
            if (s1_en) s1_valid_q <= fire_in;
            if (s1_en && fire_in) begin
                e_q         <= ext;
                e2_q        <= ext << 1;
                s1_signed_q <= in_signed;
            end
            if (s2_en) s2_valid_q <= s1_valid_q;
            if (s2_en && s1_valid_q) begin
                bank_out_q   <= bank_d;
                out_signed_q <= s1_signed_q;
            end
        end
    end
endmodule
